popcount_stream_acc: RTL and testbench
======================================

Name: popcount_stream_acc

Overview:
- Streaming consumer that accumulates the Hamming weight of a burst of data words over a valid/ready input stream.
- Each beat's word goes through an internal popcount adder-tree instance (INPUT_WIDTH = DATA_WIDTH). The per-beat weight is summed into a running total.
- At burst end (last beat, or beat limit reached), the total and the beat count are presented on a valid/ready output stream.
- Typical users: bitmap and occupancy statistics, mask density monitors and similar blocks on the datapath.

Parameters:
- DATA_WIDTH, 64, width of each input word; must be >= 2.
- MAX_BEATS, 256, maximum beats per burst; must be >= 1.
- BEAT_WIDTH, $clog2(MAX_BEATS+1), width of beats_o.
- CNT_WIDTH, $clog2(DATA_WIDTH*MAX_BEATS+1), width of count_o; the accumulator can never wrap.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; synchronous, active-low.
- clr_i  input  1  synchronous abort of the current burst.
- valid_i  input  1  input beat valid.
- ready_o  output  1  input beat accepted when valid_i && ready_o.
- data_i  input  DATA_WIDTH  input word.
- last_i  input  1  marks the final beat of a burst.
- valid_o  output  1  result valid.
- ready_i  input  1  result consumed when valid_o && ready_i.
- count_o  output  CNT_WIDTH  total number of ones in the burst.
- beats_o  output  BEAT_WIDTH  number of beats in the burst.
- overflow_o  output  1  burst was terminated by MAX_BEATS, not by last_i.

Behaviour:
- Reset: rst_ni low at a rising edge puts the FSM in ACCUM and clears accumulator and beat counter.
  - Reset values: valid_o=0, count_o=0, beats_o=0, overflow_o=0. Reset mid-burst discards all partial state.
- FSM has two states, ACCUM and OUT.
- ACCUM:
  - ready_o = !clr_i; valid_o = 0.
  - On handshake: acc <= acc + pc(data_i) (zero-extended to CNT_WIDTH); beats <= beats + 1.
  - Terminating beat = last_i || (beats == MAX_BEATS-1). On a terminating beat:
    - count_o <= acc + pc(data_i); beats_o <= beats + 1; overflow_o <= !last_i.
    - acc and beats are cleared; next state OUT.
  - last_i coinciding with the beat limit gives overflow_o=0.
- OUT:
  - valid_o=1, ready_o=0.
  - count_o, beats_o and overflow_o are held stable until handshake.
  - On ready_i: valid_o <= 0, next state ACCUM.
  - There is one bubble cycle: no input beat is accepted in the cycle the result is consumed.
- clr_i:
  - In ACCUM: acc and beats are cleared next cycle; no beat is accepted that cycle.
  - In OUT: the pending result is dropped; valid_o=0 next cycle; state goes to ACCUM.
  - clr_i has priority over ready_i.
- Latency: valid_o rises one cycle after the terminating beat handshake.
- MAX_BEATS=1: every beat terminates; overflow_o = !last_i.
- count_o, beats_o and overflow_o update only on a terminating beat or reset. Their values while valid_o=0 are don't-care to consumers.

Optional Feature:
- Macro: POPCOUNT_STREAM_ACC_PIPE_EN.
- Defined:
  - A register stage (pc value, terminating flag, last flag, valid) sits between the popcount tree and the accumulator adder.
  - ready_o = state==ACCUM && !clr_i && !(stage valid && stage terminating).
  - The accumulator adds from the stage register.
  - valid_o rises two cycles after the terminating beat handshake.
  - clr_i also invalidates the stage.
  - Throughput within a burst stays one beat per cycle.
- Undefined: purely combinational popcount into the adder, with latency as specified above.

Test Plan:
- Single-beat burst: data_i=0, last_i=1 -> one cycle later valid_o=1, count_o=0, beats_o=1, overflow_o=0.
- Three beats of 64'hFFFF_FFFF_FFFF_FFFF, last on beat 3, ready_i=1 -> count_o=192, beats_o=3, overflow_o=0; ready_o=0 for exactly the OUT cycle.
- MAX_BEATS=4, five beats of 64'h1 with no last_i -> result count_o=4, beats_o=4, overflow_o=1; fifth beat starts a new burst whose result is count_o=1 if last.
- Backpressure: hold ready_i=0 for 10 cycles after result (count_o=5) -> valid_o, count_o and beats_o stable throughout; ready_o=0; valid_i beats are not accepted.
- clr_i mid-burst after two beats of 64'hF, then one beat 64'h3 with last -> count_o=2, beats_o=1; clr_i in OUT -> valid_o drops and no result is delivered.
- rst_ni low mid-burst for one cycle, then a burst 64'hFF, 64'hFF(last) -> count_o=16, beats_o=2. Repeat all tests with POPCOUNT_STREAM_ACC_PIPE_EN defined and check the +1 cycle latency.

Source files
------------

// File: rtl/popcount_stream_acc.sv
// rtl/popcount_stream_acc.sv - burst Hamming-weight accumulator over a valid/ready stream.
// Optional POPCOUNT_STREAM_ACC_PIPE_EN adds a register stage between popcount tree and accumulator.

module popcount_tree #(
    parameter int INPUT_WIDTH = 64,
    parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
    input  logic [INPUT_WIDTH-1:0] data_i,
    output logic [COUNT_WIDTH-1:0] count_o
);
    localparam int LEVELS = $clog2(INPUT_WIDTH);
    localparam int LEAVES = 1 << LEVELS;

    // Leaves are padded to a power of two with zeros; every level halves the node count.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [COUNT_WIDTH-1:0] sum [LEAVES >> l];
        if (l == 0) begin : g_leaves
            for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
                if (i < INPUT_WIDTH) begin : g_bit
                    assign sum[i] = COUNT_WIDTH'(data_i[i]);
                end else begin : g_pad
                    assign sum[i] = '0;
                end
            end
        end else begin : g_nodes
            for (genvar k = 0; k < (LEAVES >> l); k++) begin : g_add
                assign sum[k] = g_lvl[l-1].sum[2*k] + g_lvl[l-1].sum[2*k+1];
            end
        end
    end

    assign count_o = g_lvl[LEVELS].sum[0];
endmodule

module popcount_stream_acc #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS  = 256,
    parameter int BEAT_WIDTH = $clog2(MAX_BEATS + 1),
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH * MAX_BEATS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic [BEAT_WIDTH-1:0] beats_o,
    output logic                  overflow_o
);
    localparam int PC_WIDTH = $clog2(DATA_WIDTH + 1);

    typedef enum logic {ST_ACCUM, ST_OUT} state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [BEAT_WIDTH-1:0] beats_q, beats_d;
    logic [BEAT_WIDTH-1:0] beats_out_q, beats_out_d;
    logic                  ovf_q, ovf_d;

    logic [PC_WIDTH-1:0]   pc;
    logic                  in_hs;
    logic                  in_term;
    logic [BEAT_WIDTH-1:0] beats_in;

    logic                  add_valid;
    logic                  add_term;
    logic                  add_last;
    logic [PC_WIDTH-1:0]   add_pc;

    popcount_tree #(
        .INPUT_WIDTH (DATA_WIDTH),
        .COUNT_WIDTH (PC_WIDTH)
    ) u_popcount (
        .data_i  (data_i),
        .count_o (pc)
    );

    // Beats are counted at the input so the beat limit is known as the beat is accepted.
    assign in_hs    = valid_i && ready_o;
    assign in_term  = last_i || (beats_q == BEAT_WIDTH'(MAX_BEATS - 1));
    assign beats_in = beats_q + BEAT_WIDTH'(in_hs);

`ifdef POPCOUNT_STREAM_ACC_PIPE_EN
    logic                st_valid_q, st_valid_d;
    logic                st_term_q, st_term_d;
    logic                st_last_q, st_last_d;
    logic [PC_WIDTH-1:0] st_pc_q, st_pc_d;

    assign ready_o   = (state_q == ST_ACCUM) && !clr_i && !(st_valid_q && st_term_q);
    assign add_valid = st_valid_q;
    assign add_term  = st_term_q;
    assign add_last  = st_last_q;
    assign add_pc    = st_pc_q;

    always_comb begin
        st_valid_d = in_hs;
        st_term_d  = in_term;
        st_last_d  = last_i;
        st_pc_d    = pc;
        if (clr_i) begin
            st_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            st_valid_q <= 1'b0;
            st_term_q  <= 1'b0;
            st_last_q  <= 1'b0;
            st_pc_q    <= '0;
        end else begin
            st_valid_q <= st_valid_d;
            st_term_q  <= st_term_d;
            st_last_q  <= st_last_d;
            st_pc_q    <= st_pc_d;
        end
    end
`else
    assign ready_o   = (state_q == ST_ACCUM) && !clr_i;
    assign add_valid = in_hs;
    assign add_term  = in_term;
    assign add_last  = last_i;
    assign add_pc    = pc;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        count_d     = count_q;
        beats_out_d = beats_out_q;
        ovf_d       = ovf_q;
        case (state_q)
            ST_ACCUM: begin
                if (clr_i) begin
                    acc_d   = '0;
                    beats_d = '0;
                end else begin
                    beats_d = beats_in;
                    if (add_valid) begin
                        if (add_term) begin
                            count_d     = acc_q + CNT_WIDTH'(add_pc);
                            beats_out_d = beats_in;
                            ovf_d       = !add_last;
                            acc_d       = '0;
                            beats_d     = '0;
                            state_d     = ST_OUT;
                        end else begin
                            acc_d = acc_q + CNT_WIDTH'(add_pc);
                        end
                    end
                end
            end
            ST_OUT: begin
                if (clr_i || ready_i) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            beats_q     <= '0;
            count_q     <= '0;
            beats_out_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            count_q     <= count_d;
            beats_out_q <= beats_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign valid_o    = (state_q == ST_OUT);
    assign count_o    = count_q;
    assign beats_o    = beats_out_q;
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_popcount_stream_acc.sv
// tb/tb_popcount_stream_acc.sv - directed and randomized checks of popcount_stream_acc (MAX_BEATS=4).

module tb_popcount_stream_acc;
    localparam int DW = 64;
    localparam int MB = 4;
    localparam int BW = $clog2(MB + 1);
    localparam int CW = $clog2(DW * MB + 1);
`ifdef POPCOUNT_STREAM_ACC_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          valid_in = 1'b0;
    logic          last_in = 1'b0;
    logic          ready_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          ready_out;
    logic          valid_out;
    logic          ovf_out;
    logic [CW-1:0] count_out;
    logic [BW-1:0] beats_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    popcount_stream_acc #(
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MB)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clr_i      (clr),
        .valid_i    (valid_in),
        .ready_o    (ready_out),
        .data_i     (data_in),
        .last_i     (last_in),
        .valid_o    (valid_out),
        .ready_i    (ready_in),
        .count_o    (count_out),
        .beats_o    (beats_out),
        .overflow_o (ovf_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_burst(input logic [63:0] d, input int n, input bit last_at_end);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b1;
            data_in  = d;
            last_in  = last_at_end && (i == n - 1);
            #1;
            for (int w = 0; w < 20 && !ready_out; w++) step();
            chk("beat_ready", ready_out, 1);
            step();
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int c, input int b, input bit o);
        int n;
        n = 1;
        while (!valid_out && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, LAT);
        chk({tag, "_count"}, count_out, c);
        chk({tag, "_beats"}, beats_out, b);
        chk({tag, "_ovf"}, ovf_out, o);
        chk({tag, "_ready_out"}, ready_out, 0);
    endtask

    task automatic consume(input string tag);
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        chk({tag, "_valid_after"}, valid_out, 0);
        chk({tag, "_ready_after"}, ready_out, 1);
    endtask

    // Reference model: expected results as a queue of {count, beats, overflow} per burst.
    int          exp_cnt_q[$];
    int          exp_beats_q[$];
    bit          exp_ovf_q[$];
    int          m_sum;
    int          m_beats;
    int          n_results;

    initial begin
        step();
        step();
        chk("rst_valid", valid_out, 0);
        chk("rst_count", count_out, 0);
        chk("rst_beats", beats_out, 0);
        chk("rst_ovf", ovf_out, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", ready_out, 1);

        send_burst(64'h0, 1, 1'b1);
        wait_result("single", 0, 1, 1'b0);
        consume("single");

        send_burst(64'hFFFF_FFFF_FFFF_FFFF, 3, 1'b1);
        wait_result("ones3", 192, 3, 1'b0);
        consume("ones3");

        send_burst(64'h1, 4, 1'b0);
        wait_result("limit", 4, 4, 1'b1);
        consume("limit");
        send_burst(64'h1, 1, 1'b1);
        wait_result("limit_next", 1, 1, 1'b0);
        consume("limit_next");

        send_burst(64'h8000_0000_0000_0101, 4, 1'b1);
        wait_result("last_at_limit", 12, 4, 1'b0);
        consume("last_at_limit");

        send_burst(64'h1F, 1, 1'b1);
        wait_result("bp", 5, 1, 1'b0);
        valid_in = 1'b1;
        data_in  = 64'hFFFF;
        last_in  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", valid_out, 1);
            chk("bp_count", count_out, 5);
            chk("bp_beats", beats_out, 1);
            chk("bp_ready", ready_out, 0);
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
        consume("bp");
        send_burst(64'h3, 1, 1'b1);
        wait_result("bp_after", 2, 1, 1'b0);
        consume("bp_after");

        send_burst(64'hF, 2, 1'b0);
        clr = 1'b1;
        #1;
        chk("clr_ready", ready_out, 0);
        step();
        clr = 1'b0;
        send_burst(64'h3, 1, 1'b1);
        wait_result("clr_accum", 2, 1, 1'b0);
        consume("clr_accum");

        send_burst(64'h7, 1, 1'b1);
        wait_result("clr_out_pre", 3, 1, 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("clr_out_dropped", valid_out, 0);
            step();
        end
        ready_in = 1'b0;
        send_burst(64'h1, 1, 1'b1);
        wait_result("clr_out_next", 1, 1, 1'b0);
        consume("clr_out_next");

        send_burst(64'hFFFF, 2, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        send_burst(64'hFF, 2, 1'b1);
        wait_result("rst_mid", 16, 2, 1'b0);
        consume("rst_mid");

        // Random traffic against the queue model.
        m_sum     = 0;
        m_beats   = 0;
        n_results = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic hs_in, hs_out;
            valid_in = ($urandom_range(0, 3) != 0);
            data_in  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) data_in = data_in & {$urandom, $urandom};
            last_in  = ($urandom_range(0, 4) == 0);
            ready_in = ($urandom_range(0, 1) == 1);
            #1;
            hs_in  = valid_in && ready_out;
            hs_out = valid_out && ready_in;
            if (hs_out) begin
                if (exp_cnt_q.size() == 0) begin
                    chk("rand_unexpected_result", 1, 0);
                end else begin
                    chk("rand_count", count_out, exp_cnt_q.pop_front());
                    chk("rand_beats", beats_out, exp_beats_q.pop_front());
                    chk("rand_ovf", ovf_out, exp_ovf_q.pop_front());
                    n_results++;
                end
            end
            if (hs_in) begin
                m_sum   += $countones(data_in);
                m_beats += 1;
                if (last_in || m_beats == MB) begin
                    exp_cnt_q.push_back(m_sum);
                    exp_beats_q.push_back(m_beats);
                    exp_ovf_q.push_back(!last_in);
                    m_sum   = 0;
                    m_beats = 0;
                end
            end
            step();
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
        ready_in = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (valid_out) begin
                if (exp_cnt_q.size() == 0) begin
                    chk("drain_unexpected_result", 1, 0);
                end else begin
                    chk("drain_count", count_out, exp_cnt_q.pop_front());
                    chk("drain_beats", beats_out, exp_beats_q.pop_front());
                    chk("drain_ovf", ovf_out, exp_ovf_q.pop_front());
                    n_results++;
                end
            end
            step();
        end
        ready_in = 1'b0;
        chk("rand_queue_empty", exp_cnt_q.size(), 0);
        chk("rand_some_results", (n_results > 20), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
